sram_controller_param: RTL and testbench

// - Parametrised external-SRAM controller; successor of the fixed 32b-over-16b controller.
// - Splits one DATA_W host word into DATA_W/SRAM_DQ_W beats over a narrow async SRAM.
// - Programmable wait states per beat; registered pin outputs; explicit read-valid pulse.
// - Sits between the MEM stage / cache refill and the SRAM pins.

---
 rtl/sram_controller_param_pkg.sv | 19 +
 rtl/sram_controller_param_if.sv | 15 +
 rtl/sram_beat_counter.sv | 49 ++++
 rtl/sram_controller_param.sv | 107 ++++++++++
 tb/tb_sram_controller_param.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_controller_param_pkg.sv
// Shared types and helpers for the parametrised external-SRAM controller.
package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/sram_controller_param_if.sv
// Host-side request/response bus of the SRAM controller.
interface sram_controller_param_if #(parameter int DATA_W = 32);
    logic              writeEn;
    logic              readEn;
    logic [31:0]       address;
    logic [DATA_W-1:0] WriteData;
    logic [DATA_W-1:0] ReadData;
    logic              readValid;
    logic              ready;

    modport master (output writeEn, readEn, address, WriteData,
                    input  ReadData, readValid, ready);
    modport slave  (input  writeEn, readEn, address, WriteData,
                    output ReadData, readValid, ready);
endinterface

// File: rtl/sram_beat_counter.sv
// Wait-state and beat counters; exposes next values so the top can register pins early.
module sram_beat_counter #(
    parameter int NBEAT       = 2,
    parameter int WAIT_CYCLES = 1,
    parameter int BCW         = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clear,
    input  logic           en,
    output logic [BCW-1:0] beat,
    output logic [BCW-1:0] beat_nxt,
    output logic [3:0]     wt_nxt,
    output logic           beat_last,
    output logic           xfer_last
);
    logic [3:0] wt;

    always_comb begin
        beat_last = (wt == 4'(WAIT_CYCLES));
        xfer_last = beat_last && (beat == BCW'(NBEAT-1));
        beat_nxt  = beat;
        wt_nxt    = wt;
        if (clear) begin
            beat_nxt = '0;
            wt_nxt   = '0;
        end else if (en) begin
            if (xfer_last) begin
                beat_nxt = '0;
                wt_nxt   = '0;
            end else if (beat_last) begin
                beat_nxt = beat + 1'b1;
                wt_nxt   = '0;
            end else begin
                wt_nxt = wt + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat <= '0;
            wt   <= '0;
        end else begin
            beat <= beat_nxt;
            wt   <= wt_nxt;
        end
    end
endmodule

// File: rtl/sram_controller_param.sv
// Splits a DATA_W host word into SRAM_DQ_W beats over an async SRAM; all pins registered.
module sram_controller_param
    import sram_ctrl_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int SRAM_DQ_W   = 16,
    parameter int SRAM_ADDR_W = 18,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    sram_controller_param_if.slave   host,
    output logic [SRAM_ADDR_W-1:0]   SRAM_ADDR,
    output logic                     SRAM_WE_N,
    output logic                     SRAM_OE_N,
    inout  wire  [SRAM_DQ_W-1:0]     SRAM_DQ
);
    localparam int NBEAT = DATA_W / SRAM_DQ_W;
    localparam int BW    = clog2(NBEAT);
    localparam int BCW   = (BW > 0) ? BW : 1;
    localparam int WB    = clog2(DATA_W / 8);

    state_t state, state_n;
    logic [31:0] addr_q, addr_n;
    logic [NBEAT-1:0][SRAM_DQ_W-1:0] wdata_q, wdata_n, rd_buf, rd_nxt;
    logic [DATA_W-1:0]      rdata_q;
    logic                   rvalid_q;
    logic [SRAM_DQ_W-1:0]   dq_out, dq_out_d;
    logic                   dq_oe, dq_oe_d;
    logic [SRAM_ADDR_W-1:0] sram_addr_d;
    logic                   we_n_d, oe_n_d;
    logic [BCW-1:0]         beat, beat_nxt;
    logic [3:0]             wt_nxt;
    logic                   beat_last, xfer_last, accept, active;

    assign accept = (state == IDLE) && (host.writeEn || host.readEn);
    assign active = (state == WRITE) || (state == READ);

    sram_beat_counter #(.NBEAT(NBEAT), .WAIT_CYCLES(WAIT_CYCLES), .BCW(BCW)) u_cnt (
        .clk(clk), .rst(rst), .clear(accept), .en(active),
        .beat(beat), .beat_nxt(beat_nxt), .wt_nxt(wt_nxt),
        .beat_last(beat_last), .xfer_last(xfer_last)
    );

    // Each lane latches the pin bus on the last cycle of its own beat.
    for (genvar i = 0; i < NBEAT; i++) begin : g_lane
        assign rd_nxt[i] = (state == READ && beat_last && beat == BCW'(i)) ? SRAM_DQ : rd_buf[i];
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Pins are registered from next-cycle state so they line up with the counters.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (host.writeEn)     state_n = WRITE;
                     else if (host.readEn) state_n = READ;
            WRITE:   if (xfer_last)        state_n = IDLE;
            READ:    if (xfer_last)        state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        addr_n      = accept ? host.address : addr_q;
        wdata_n     = accept ? host.WriteData : wdata_q;
        sram_addr_d = SRAM_ADDR;
        if (state_n == WRITE || state_n == READ)
            sram_addr_d = SRAM_ADDR_W'((addr_n >> WB) * NBEAT + int'(beat_nxt));
        we_n_d   = !(state_n == WRITE && (WAIT_CYCLES == 0 || wt_nxt != 4'd0));
        oe_n_d   = !(state_n == READ);
        dq_oe_d  = (state_n == WRITE);
        dq_out_d = wdata_n[beat_nxt];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_buf    <= '0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
            SRAM_ADDR <= '0;
            SRAM_WE_N <= 1'b1;
            SRAM_OE_N <= 1'b1;
            dq_oe     <= 1'b0;
            dq_out    <= '0;
        end else begin
            addr_q    <= addr_n;
            wdata_q   <= wdata_n;
            rd_buf    <= rd_nxt;
            rvalid_q  <= (state_n == DONE);
            if (state == READ && xfer_last) rdata_q <= rd_nxt;
            SRAM_ADDR <= sram_addr_d;
            SRAM_WE_N <= we_n_d;
            SRAM_OE_N <= oe_n_d;
            dq_oe     <= dq_oe_d;
            dq_out    <= dq_out_d;
        end
    end

    assign SRAM_DQ        = dq_oe ? dq_out : 'z;
    assign host.ReadData  = rdata_q;
    assign host.readValid = rvalid_q;
    assign host.ready     = (state == IDLE);
endmodule

// File: tb/tb_sram_controller_param.sv
// Bench for sram_controller_param: default 32/16 instance and a 64-bit zero-wait instance.
module tb_sram_controller_param;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int rv_cnt_a = 0;
    int rv_cnt_b = 0;

    sram_controller_param_if #(.DATA_W(32)) bus_a ();
    sram_controller_param_if #(.DATA_W(64)) bus_b ();

    logic [17:0] addr_a, addr_b;
    logic        we_a, oe_a, we_b, oe_b;
    wire  [15:0] dq_a, dq_b;
    logic [15:0] mem_a [0:(1<<18)-1];
    logic [15:0] mem_b [0:(1<<18)-1];

    // Async SRAM models: drive on OE_N low, write on WE_N low at the clock edge.
    assign dq_a = (!oe_a && we_a) ? mem_a[addr_a] : 'z;
    assign dq_b = (!oe_b && we_b) ? mem_b[addr_b] : 'z;
    always @(posedge clk) if (!we_a) mem_a[addr_a] <= dq_a;
    always @(posedge clk) if (!we_b) mem_b[addr_b] <= dq_b;

    sram_controller_param #(.DATA_W(32), .SRAM_DQ_W(16), .SRAM_ADDR_W(18), .WAIT_CYCLES(1)) dut_a (
        .clk(clk), .rst(rst), .host(bus_a),
        .SRAM_ADDR(addr_a), .SRAM_WE_N(we_a), .SRAM_OE_N(oe_a), .SRAM_DQ(dq_a));

    sram_controller_param #(.DATA_W(64), .SRAM_DQ_W(16), .SRAM_ADDR_W(18), .WAIT_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst), .host(bus_b),
        .SRAM_ADDR(addr_b), .SRAM_WE_N(we_b), .SRAM_OE_N(oe_b), .SRAM_DQ(dq_b));

    typedef struct packed {
        logic [17:0] a;
        logic [15:0] d;
        logic        we;
    } pin_t;

    pin_t        pin_qa[$], pin_qb[$];
    logic [63:0] rd_qa[$], rd_qb[$];
    pin_t        ea, eb;
    logic [63:0] ra, rb;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitors: write beats pop pin expectations, readValid pops read data.
    always @(negedge clk) begin
        if (!rst && dut_a.dq_oe) begin
            if (pin_qa.size() == 0) begin
                checks++; errors++;
                $error("FAIL a_pin_unexp: observed addr %0h expected no write beat", addr_a);
            end else begin
                ea = pin_qa.pop_front();
                chk("a_pin_addr", 64'(addr_a), 64'(ea.a));
                chk("a_pin_dq",   64'(dq_a),   64'(ea.d));
                chk("a_pin_we",   64'(we_a),   64'(ea.we));
            end
        end
        if (!rst && bus_a.readValid) begin
            rv_cnt_a++;
            if (rd_qa.size() == 0) begin
                checks++; errors++;
                $error("FAIL a_rv_unexp: observed %0h expected no readValid", bus_a.ReadData);
            end else begin
                ra = rd_qa.pop_front();
                chk("a_rdata", 64'(bus_a.ReadData), ra);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && dut_b.dq_oe) begin
            if (pin_qb.size() == 0) begin
                checks++; errors++;
                $error("FAIL b_pin_unexp: observed addr %0h expected no write beat", addr_b);
            end else begin
                eb = pin_qb.pop_front();
                chk("b_pin_addr", 64'(addr_b), 64'(eb.a));
                chk("b_pin_dq",   64'(dq_b),   64'(eb.d));
                chk("b_pin_we",   64'(we_b),   64'(eb.we));
            end
        end
        if (!rst && bus_b.readValid) begin
            rv_cnt_b++;
            if (rd_qb.size() == 0) begin
                checks++; errors++;
                $error("FAIL b_rv_unexp: observed %0h expected no readValid", bus_b.ReadData);
            end else begin
                rb = rd_qb.pop_front();
                chk("b_rdata", bus_b.ReadData, rb);
            end
        end
    end

    // L=2: each beat shows one setup cycle (WE_N=1) then one strobe cycle (WE_N=0).
    task automatic push_a(input logic [31:0] ad, input logic [31:0] d);
        logic [17:0] base;
        base = 18'((ad >> 2) * 2);
        for (int b = 0; b < 2; b++) begin
            pin_qa.push_back('{a: base + 18'(b), d: d[16*b +: 16], we: 1'b1});
            pin_qa.push_back('{a: base + 18'(b), d: d[16*b +: 16], we: 1'b0});
        end
    endtask

    task automatic wr_a(input logic [31:0] ad, input logic [31:0] d, input bit hold);
        bus_a.writeEn   = 1'b1;
        bus_a.address   = ad;
        bus_a.WriteData = d;
        push_a(ad, d);
        @(negedge clk);
        if (!hold) bus_a.writeEn = 1'b0;
        bus_a.address   = 32'hFFFF_FFFC;
        bus_a.WriteData = ~d;
    endtask

    task automatic wait_ready_a(input string tag, input int start, input int exp);
        int n;
        n = start;
        while (!bus_a.ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'(n), 64'(exp));
    endtask

    task automatic rd_a(input logic [31:0] ad, input logic [31:0] d, input string tag);
        int n;
        bus_a.readEn  = 1'b1;
        bus_a.address = ad;
        rd_qa.push_back(64'(d));
        @(negedge clk);
        bus_a.readEn  = 1'b0;
        bus_a.address = 32'h0;
        chk({tag, "_oe"}, 64'(oe_a), 64'd0);
        chk({tag, "_we"}, 64'(we_a), 64'd1);
        chk({tag, "_dqoff"}, 64'(dut_a.dq_oe), 64'd0);
        n = 1;
        while (!bus_a.readValid && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_lat"}, 64'(n), 64'd5);
        @(negedge clk);
        chk({tag, "_pulse"}, 64'(bus_a.readValid), 64'd0);
        chk({tag, "_ready"}, 64'(bus_a.ready), 64'd1);
    endtask

    initial begin
        int n, rv0;
        logic [63:0] wb;
        bus_a.writeEn = 1'b0; bus_a.readEn = 1'b0; bus_a.address = '0; bus_a.WriteData = '0;
        bus_b.writeEn = 1'b0; bus_b.readEn = 1'b0; bus_b.address = '0; bus_b.WriteData = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_we",    64'(we_a), 64'd1);
        chk("rst_oe",    64'(oe_a), 64'd1);
        chk("rst_addr",  64'(addr_a), 64'd0);
        chk("rst_rv",    64'(bus_a.readValid), 64'd0);
        chk("rst_rdata", 64'(bus_a.ReadData), 64'd0);
        chk("rst_dqoff", 64'(dut_a.dq_oe), 64'd0);
        chk("rst_ready", 64'(bus_a.ready), 64'd1);
        chk("rst_b_ready", 64'(bus_b.ready), 64'd1);

        // Write 0xDEADBEEF @0x8; a read pulsed while busy must be dropped
        wr_a(32'h8, 32'hDEADBEEF, 1'b0);
        bus_a.readEn = 1'b1;
        @(negedge clk);
        bus_a.readEn = 1'b0;
        wait_ready_a("wr_ready_cycle", 2, 5);
        @(negedge clk);
        chk("busy_req_ignored", 64'(bus_a.ready), 64'd1);
        chk("wr_beats_done", 64'(pin_qa.size()), 64'd0);

        rd_a(32'h8, 32'hDEADBEEF, "rd8");

        // Simultaneous write+read: the write wins, no readValid
        rv0 = rv_cnt_a;
        bus_a.readEn = 1'b1;
        wr_a(32'h0, 32'h12345678, 1'b0);
        bus_a.readEn = 1'b0;
        wait_ready_a("both_ready", 1, 5);
        repeat (2) @(negedge clk);
        chk("both_no_rv", 64'(rv_cnt_a - rv0), 64'd0);
        rd_a(32'h0, 32'h12345678, "rd0");

        // Back-to-back writes with writeEn held high
        wr_a(32'h10, 32'hCAFEF00D, 1'b1);
        bus_a.address   = 32'h14;
        bus_a.WriteData = 32'h0BADC0DE;
        push_a(32'h14, 32'h0BADC0DE);
        wait_ready_a("b2b_first_ready", 1, 5);
        @(negedge clk);
        bus_a.writeEn = 1'b0;
        chk("b2b_second_accepted", 64'(bus_a.ready), 64'd0);
        wait_ready_a("b2b_second_ready", 1, 5);
        chk("b2b_beats_done", 64'(pin_qa.size()), 64'd0);

        // Back-to-back reads with readEn held high
        bus_a.readEn  = 1'b1;
        bus_a.address = 32'h10;
        rd_qa.push_back(64'h0000_0000_CAFE_F00D);
        @(negedge clk);
        n = 1;
        while (!bus_a.readValid && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_rd1_lat", 64'(n), 64'd5);
        bus_a.address = 32'h14;
        rd_qa.push_back(64'h0000_0000_0BAD_C0DE);
        @(negedge clk);
        n = 1;
        while (!bus_a.readValid && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_rd2_lat", 64'(n), 64'd6);
        bus_a.readEn = 1'b0;
        @(negedge clk);

        // Reset for two cycles in the middle of a read
        rv0 = rv_cnt_a;
        bus_a.readEn  = 1'b1;
        bus_a.address = 32'h8;
        @(negedge clk);
        bus_a.readEn = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_we", 64'(we_a), 64'd1);
        chk("mid_rst_oe", 64'(oe_a), 64'd1);
        chk("mid_rst_dqoff", 64'(dut_a.dq_oe), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        chk("post_rst_ready", 64'(bus_a.ready), 64'd1);
        chk("post_rst_rdata", 64'(bus_a.ReadData), 64'd0);
        chk("post_rst_rv", 64'(bus_a.readValid), 64'd0);
        repeat (6) @(negedge clk);
        chk("aborted_no_rv", 64'(rv_cnt_a - rv0), 64'd0);
        rd_a(32'h8, 32'hDEADBEEF, "rd8_after_rst");

        // 64-bit, zero-wait instance: four single-cycle strobed beats
        wb = 64'h0123_4567_89AB_CDEF;
        bus_b.writeEn   = 1'b1;
        bus_b.address   = 32'h10;
        bus_b.WriteData = wb;
        for (int b = 0; b < 4; b++)
            pin_qb.push_back('{a: 18'd8 + 18'(b), d: wb[16*b +: 16], we: 1'b0});
        @(negedge clk);
        bus_b.writeEn   = 1'b0;
        bus_b.WriteData = '1;
        n = 1;
        while (!bus_b.ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("b_wr_ready_cycle", 64'(n), 64'd5);
        chk("b_wr_beats_done", 64'(pin_qb.size()), 64'd0);
        bus_b.readEn = 1'b1;
        rd_qb.push_back(wb);
        @(negedge clk);
        bus_b.readEn = 1'b0;
        n = 1;
        while (!bus_b.readValid && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("b_rd_lat", 64'(n), 64'd5);
        repeat (2) @(negedge clk);
        chk("b_rv_count", 64'(rv_cnt_b), 64'd1);
        chk("rd_queue_empty", 64'(rd_qa.size() + rd_qb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no completion expected finish within 200000 time units");
        $fatal(1, "watchdog expired");
    end
endmodule
